// File: rtl/tick_scheduler_pkg.sv
// Shared constants for the tick scheduler: channel count, width,
// register addresses and the scan FSM state encoding.
package tick_scheduler_pkg;

    localparam int NUM_CH = 4;
    localparam int CW     = 16;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIOD0 = 3'd2;
    localparam logic [2:0] ADDR_PERIOD1 = 3'd3;
    localparam logic [2:0] ADDR_PERIOD2 = 3'd4;
    localparam logic [2:0] ADDR_PERIOD3 = 3'd5;
    localparam logic [2:0] ADDR_CURSEL  = 3'd6;
    localparam logic [2:0] ADDR_COUNT   = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/tick_sched_chan_dec.sv
// Shared compare/decrement/reload datapath; the scan FSM routes one
// channel through it per cycle.
module tick_sched_chan_dec #(
    parameter int W = 16
) (
    input  logic         service,
    input  logic         enable,
    input  logic         one_shot,
    input  logic [W-1:0] count,
    input  logic [W-1:0] period,
    output logic         update,
    output logic         expire,
    output logic         disarm,
    output logic [W-1:0] next_count
);

    // A zero period parks the channel: it neither counts nor expires.
    always_comb begin
        update     = service & enable & (period != '0);
        expire     = update & (count <= W'(1));
        disarm     = expire & one_shot;
        next_count = expire ? period : count - W'(1);
    end

endmodule

// File: rtl/tick_scheduler.sv
// Avalon-MM software timer block: NUM_CH channels decremented once per
// tick by a time-shared scan engine, with W1C status and level irq.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int NUM_CH = tick_scheduler_pkg::NUM_CH,
    parameter int CW     = tick_scheduler_pkg::CW
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        busy
);

    localparam int IW = $clog2(NUM_CH);

    state_t            state, state_next;
    logic [IW-1:0]     idx, idx_next;
    logic              pending, pending_next;
    logic              overrun_set;

    logic              overrun;
    logic [NUM_CH-1:0] expired, ch_en, irq_en, one_shot;
    logic [IW-1:0]     cursel;
    logic [CW-1:0]     period [NUM_CH];
    logic [CW-1:0]     count  [NUM_CH];

    logic              wr, wr_status, wr_control, wr_cursel;
    logic              update, expire, disarm;
    logic [CW-1:0]     next_count;
    logic [NUM_CH-1:0] expire_mask;
    logic [15:0]       rd_mux;

    assign wr         = chipselect & ~write_n;
    assign wr_status  = wr && (address == ADDR_STATUS);
    assign wr_control = wr && (address == ADDR_CONTROL);
    assign wr_cursel  = wr && (address == ADDR_CURSEL);

    assign busy = (state == SCAN);
    assign irq  = |(expired & irq_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            pending <= pending_next;
        end
    end

    // A tick during a scan is held one deep; a second one is dropped and flagged.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        pending_next = pending;
        overrun_set  = 1'b0;
        case (state)
            IDLE: begin
                if (tick || pending) begin
                    state_next   = SCAN;
                    idx_next     = '0;
                    pending_next = 1'b0;
                end
            end
            SCAN: begin
                idx_next = idx + IW'(1);
                if (idx == IW'(NUM_CH - 1)) begin
                    idx_next = '0;
                    if (pending) pending_next = 1'b0;
                    else         state_next   = IDLE;
                end
                if (tick) begin
                    if (pending) overrun_set  = 1'b1;
                    else         pending_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    tick_sched_chan_dec #(.W(CW)) u_dec (
        .service    (busy),
        .enable     (ch_en[idx]),
        .one_shot   (one_shot[idx]),
        .count      (count[idx]),
        .period     (period[idx]),
        .update     (update),
        .expire     (expire),
        .disarm     (disarm),
        .next_count (next_count)
    );

    always_comb begin
        expire_mask = '0;
        if (expire) expire_mask[idx] = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[15]         = overrun;
                rd_mux[NUM_CH-1:0] = expired;
            end
            ADDR_CONTROL: begin
                rd_mux[NUM_CH-1:0]  = ch_en;
                rd_mux[4 +: NUM_CH] = irq_en;
                rd_mux[8 +: NUM_CH] = one_shot;
            end
            ADDR_PERIOD0: rd_mux[CW-1:0] = period[0];
            ADDR_PERIOD1: rd_mux[CW-1:0] = period[1];
            ADDR_PERIOD2: rd_mux[CW-1:0] = period[2];
            ADDR_PERIOD3: rd_mux[CW-1:0] = period[3];
            ADDR_CURSEL:  rd_mux[IW-1:0] = cursel;
            ADDR_COUNT:   rd_mux[CW-1:0] = count[cursel];
            default:      rd_mux = '0;
        endcase
    end

    // Host writes take priority over the scan; set-type events win over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun  <= 1'b0;
            expired  <= '0;
            ch_en    <= '0;
            irq_en   <= '0;
            one_shot <= '0;
            cursel   <= '0;
            readdata <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                period[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (wr_status && writedata[15])
                overrun <= 1'b0;

            expired <= (expired & ~(wr_status ? writedata[NUM_CH-1:0] : '0)) | expire_mask;

            if (wr_control) begin
                ch_en    <= writedata[NUM_CH-1:0];
                irq_en   <= writedata[4 +: NUM_CH];
                one_shot <= writedata[8 +: NUM_CH];
            end else if (disarm) begin
                ch_en[idx] <= 1'b0;
            end

            if (wr_cursel) cursel <= writedata[IW-1:0];

            for (int n = 0; n < NUM_CH; n++) begin
                if (wr && (address == ADDR_PERIOD0 + 3'(n))) begin
                    period[n] <= writedata[CW-1:0];
                    count[n]  <= writedata[CW-1:0];
                end else if (wr_control && writedata[n] && !ch_en[n]) begin
                    count[n] <= period[n];
                end else if (update && (idx == IW'(n))) begin
                    count[n] <= next_count;
                end
            end

            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus random
// register/tick traffic compared against a per-tick behavioural model.
module tb_tick_scheduler;
    import tick_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [2:0]  address = '0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, advanced one whole tick at a time.
    logic [15:0] m_period [4];
    logic [15:0] m_count  [4];
    logic [3:0]  m_en, m_irqen, m_os, m_exp;
    logic        m_ovr;

    always #5 clk = ~clk;

    tick_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .busy       (busy)
    );

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_period[n] = '0;
            m_count[n]  = '0;
        end
        m_en = '0; m_irqen = '0; m_os = '0; m_exp = '0; m_ovr = 1'b0;
    endtask

    task automatic model_tick();
        for (int n = 0; n < 4; n++) begin
            if (m_en[n] && m_period[n] != 0) begin
                if (m_count[n] <= 1) begin
                    m_exp[n]   = 1'b1;
                    m_count[n] = m_period[n];
                    if (m_os[n]) m_en[n] = 1'b0;
                end else begin
                    m_count[n] = m_count[n] - 16'd1;
                end
            end
        end
    endtask

    function automatic logic [15:0] exp_status();
        return {m_ovr, 11'b0, m_exp};
    endfunction

    function automatic logic [15:0] exp_control();
        return {4'b0, m_os, m_irqen, m_en};
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        address = a;
        step(1);
        d = readdata;
    endtask

    task automatic apply_stimulus(input logic [2:0] a, input logic [15:0] d);
        bus_write(a, d);
        case (a)
            ADDR_STATUS: begin
                m_exp = m_exp & ~d[3:0];
                if (d[15]) m_ovr = 1'b0;
            end
            ADDR_CONTROL: begin
                for (int n = 0; n < 4; n++)
                    if (d[n] && !m_en[n]) m_count[n] = m_period[n];
                m_en = d[3:0]; m_irqen = d[7:4]; m_os = d[11:8];
            end
            ADDR_PERIOD0, ADDR_PERIOD1, ADDR_PERIOD2, ADDR_PERIOD3: begin
                m_period[a - ADDR_PERIOD0] = d;
                m_count[a - ADDR_PERIOD0]  = d;
            end
            default: ;
        endcase
    endtask

    task automatic apply_tick(input int gap);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(gap);
        model_tick();
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        model_reset();
    endtask

    task automatic check_regs(input string tag);
        logic [15:0] d;
        bus_read(ADDR_STATUS, d);
        check_output({tag, "_status"}, d, exp_status());
        bus_read(ADDR_CONTROL, d);
        check_output({tag, "_control"}, d, exp_control());
        check_output({tag, "_irq"}, {15'b0, irq}, {15'b0, |(m_exp & m_irqen)});
        for (int n = 0; n < 4; n++) begin
            bus_read(ADDR_PERIOD0 + 3'(n), d);
            check_output($sformatf("%s_period%0d", tag, n), d, m_period[n]);
            bus_write(ADDR_CURSEL, 16'(n));
            bus_read(ADDR_COUNT, d);
            check_output($sformatf("%s_count%0d", tag, n), d, m_count[n]);
        end
    endtask

    initial begin
        logic [15:0] d;
        int busy_cycles;

        $display("[TB] start");
        reset_dut();
        check_output("reset_readdata", readdata, 16'h0000);
        check_output("reset_busy", {15'b0, busy}, 16'h0000);
        check_regs("reset");

        // Periodic channel 0, period 3, irq enabled.
        apply_stimulus(ADDR_PERIOD0, 16'd3);
        apply_stimulus(ADDR_CONTROL, 16'h0011);
        for (int t = 1; t <= 7; t++) begin
            apply_tick(199);
            bus_read(ADDR_STATUS, d);
            check_output($sformatf("periodic_t%0d_status", t), d, exp_status());
            check_output($sformatf("periodic_t%0d_irq", t), {15'b0, irq}, {15'b0, |(m_exp & m_irqen)});
            if (t == 3) check_output("periodic_t3_irq_const", {15'b0, irq}, 16'h0001);
            if (t == 4) begin
                apply_stimulus(ADDR_STATUS, 16'h0001);
                step(1);
                check_output("periodic_w1c_irq", {15'b0, irq}, 16'h0000);
            end
        end
        check_regs("periodic_end");

        // One-shot channel 1, period 2.
        reset_dut();
        apply_stimulus(ADDR_PERIOD1, 16'd2);
        apply_stimulus(ADDR_CONTROL, 16'h0202);
        for (int t = 1; t <= 4; t++) begin
            apply_tick(8);
            bus_read(ADDR_STATUS, d);
            check_output($sformatf("oneshot_t%0d_status", t), d, exp_status());
            if (t == 2) apply_stimulus(ADDR_STATUS, 16'h0002);
        end
        bus_read(ADDR_CONTROL, d);
        check_output("oneshot_control_const", d, 16'h0200);
        check_regs("oneshot_end");

        // Three back-to-back ticks: one queued, one dropped as overrun.
        reset_dut();
        busy_cycles = 0;
        tick = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(1);
            if (busy) busy_cycles++;
        end
        tick = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (busy) busy_cycles++;
        end
        model_tick();
        model_tick();
        m_ovr = 1'b1;
        check_output("overrun_busy_cycles", 16'(busy_cycles), 16'd8);
        bus_read(ADDR_STATUS, d);
        check_output("overrun_status_const", d, 16'h8000);
        check_regs("overrun");

        // W1C on the exact cycle channel 0 expires: expire wins.
        reset_dut();
        apply_stimulus(ADDR_PERIOD0, 16'd1);
        apply_stimulus(ADDR_CONTROL, 16'h0001);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        bus_write(ADDR_STATUS, 16'h0001);
        step(4);
        model_tick();
        bus_read(ADDR_STATUS, d);
        check_output("w1c_race_status_const", d, 16'h0001);
        check_output("w1c_race_status_model", d, exp_status());

        // Live count readback and one-cycle read latency.
        reset_dut();
        apply_stimulus(ADDR_CURSEL, 16'd2);
        apply_stimulus(ADDR_PERIOD2, 16'd5);
        apply_stimulus(ADDR_CONTROL, 16'h0004);
        apply_tick(8);
        apply_tick(8);
        bus_read(ADDR_CONTROL, d);
        check_output("latency_control", d, 16'h0004);
        address = ADDR_COUNT;
        #1;
        check_output("latency_before_edge", readdata, 16'h0004);
        step(1);
        check_output("count_const", readdata, 16'd3);
        check_output("count_model", readdata, m_count[2]);

        // Reset in the middle of a scan.
        reset_dut();
        apply_stimulus(ADDR_PERIOD0, 16'd1);
        apply_stimulus(ADDR_CONTROL, 16'h0011);
        apply_tick(8);
        check_output("midscan_irq_before", {15'b0, irq}, 16'h0001);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
        check_output("midscan_busy_before", {15'b0, busy}, 16'h0001);
        reset_n = 1'b0;
        #1;
        check_output("midscan_irq", {15'b0, irq}, 16'h0000);
        check_output("midscan_busy", {15'b0, busy}, 16'h0000);
        check_output("midscan_readdata", readdata, 16'h0000);
        step(2);
        reset_n = 1'b1;
        model_reset();
        step(6);
        check_regs("midscan_after");

        // Random register and tick traffic against the model.
        reset_dut();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: apply_stimulus(ADDR_PERIOD0 + 3'($urandom_range(0, 3)), 16'($urandom_range(0, 5)));
                1: apply_stimulus(ADDR_CONTROL, 16'($urandom) & 16'h0FFF);
                2: apply_stimulus(ADDR_STATUS, 16'($urandom) & 16'h800F);
                default: apply_tick(6);
            endcase
            bus_read(ADDR_STATUS, d);
            check_output($sformatf("rand%0d_status", i), d, exp_status());
            check_output($sformatf("rand%0d_irq", i), {15'b0, irq}, {15'b0, |(m_exp & m_irqen)});
            if (i % 10 == 9) check_regs($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of software timer channels (fixed at 4 for this release).
REQ-002 Parameter CW, default 16, channel count/period width in ticks.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 tick  input  1  one-cycle pulse from the interval timer timeout (100000-cycle period).
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 address  input  3  register index.
REQ-009 writedata  input  16  write data.
REQ-010 readdata  output  16  registered read data.
REQ-011 irq  output  1  level interrupt, OR of enabled expired flags.
REQ-012 busy  output  1  high while the scan FSM is not IDLE.

Function
REQ-013 Register map SHALL be: 0 STATUS, 1 CONTROL, 2..5 PERIOD0..3, 6 CURSEL, 7 COUNT (read-only).
REQ-014 STATUS: bits[3:0] expired flags, bit15 overrun; each bit clears when written 1 (W1C); other bits read 0.
REQ-015 CONTROL: [3:0] channel enable, [7:4] irq enable, [11:8] one-shot mode; other bits read 0.
REQ-016 CURSEL[1:0] selects the channel whose live count is returned at address 7.
REQ-017 readdata SHALL equal the addressed register sampled one cycle after the address is presented (1-cycle latency, updated every cycle, independent of chipselect).
REQ-018 Write strobe = chipselect & ~write_n; writes take effect on the same clock edge.
REQ-019 Writing PERIODn SHALL load period[n] and count[n] with writedata in the same cycle.
REQ-020 A 0->1 transition of enable[n] by a CONTROL write SHALL load count[n] <= period[n].
REQ-021 FSM states IDLE and SCAN; one shared CW-bit decrementer services one channel per cycle.
REQ-022 IDLE -> SCAN on tick (or pending tick), index 0; SCAN visits channels 0,1,2,3 in consecutive cycles; after channel 3 -> SCAN (index 0) if a tick is pending, else IDLE.
REQ-023 Channel service, if enabled and period != 0: count <= 1 -> set expired[n], count <= period[n]; if one-shot, also clear enable[n]; otherwise count <= count - 1.
REQ-024 Disabled channels or period 0: count untouched, never expire.
REQ-025 Result: a periodic channel with period P expires once every P ticks; P=1 expires every tick.
REQ-026 tick arriving while busy SHALL set a one-deep pending flag; tick arriving while pending already set SHALL set STATUS.overrun and be dropped.
REQ-027 Simultaneous PERIODn write and scan of channel n: host write wins.
REQ-028 Simultaneous STATUS W1C and expire of the same channel: expire wins (flag stays 1).
REQ-029 Simultaneous CONTROL write and one-shot auto-clear: host-written enable value wins.
REQ-030 irq = |(expired[3:0] & irq_en[3:0]), combinational from registers.

Reset
REQ-031 On reset_n low, asynchronously: FSM IDLE, pending 0, STATUS 0, CONTROL 0, CURSEL 0, all period and count 0, readdata 0; hence irq 0, busy 0.
REQ-032 Reset mid-scan SHALL abandon the scan with no partial flag update after release.

Structure
REQ-033 Shared package SHALL hold register address constants, NUM_CH, CW, and the FSM state encoding.
REQ-034 One sub-module, tick_sched_chan_dec (shared compare/decrement/reload datapath), SHALL be instantiated once.

Verification
REQ-035 PERIOD0=3, CONTROL=0x0011, 7 ticks spaced 200 cycles -> expired[0] set after ticks 3 and 6, irq high after tick 3 until W1C 0x0001.
REQ-036 PERIOD1=2, CONTROL=0x0202 (one-shot), 4 ticks -> expired[1] set once after tick 2, CONTROL reads 0x0200 afterwards.
REQ-037 Three ticks on consecutive cycles -> second sets pending, third sets STATUS bit15; busy stays high 8 cycles.
REQ-038 W1C STATUS=0x0001 on the cycle channel 0 expires -> STATUS[0] reads 1.
REQ-039 CURSEL=2, PERIOD2=5, CONTROL=0x0004, 2 ticks -> COUNT reads 3; readdata valid one cycle after address.
REQ-040 Assert reset_n low during SCAN -> all registers 0, irq 0, busy 0 immediately.
